// File: rtl/fir_cascade_mac_pipe.sv
// Pipelined signed multiply-accumulate for the FIR cascade: framed beats are
// multiplied, summed, then rounded and saturated into one result per frame.
module fir_cascade_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 9,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int SHIFT      = 0,
  parameter int DOUT_WIDTH = 25
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  localparam logic signed [ACC_WIDTH:0] ONE_C   = (ACC_WIDTH + 1)'(1);
  // Half an output LSB; collapses to zero when no shift is applied.
  localparam logic signed [ACC_WIDTH:0] ROUND_C = (ONE_C << SHIFT) >> 1;
  localparam logic signed [ACC_WIDTH:0] MAX_C   = (ONE_C << (DOUT_WIDTH - 1)) - ONE_C;
  localparam logic signed [ACC_WIDTH:0] MIN_C   = ~MAX_C;

  logic                         w_ce;
  logic signed [PW-1:0]         w_prod;

  logic [NUM_STAGE-1:0]         r_vld;
  logic                         r_first [NUM_STAGE];
  logic                         r_last  [NUM_STAGE];
  logic signed [PW-1:0]         r_prod  [NUM_STAGE];

  logic                         w_tail_vld;
  logic                         w_tail_first;
  logic                         w_tail_last;
  logic signed [PW-1:0]         w_tail_prod;

  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  w_acc_base;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic signed [ACC_WIDTH:0]    w_r;
  logic signed [DOUT_WIDTH-1:0] w_dout;
  logic                         w_ovf;

  // A held result freezes the whole pipeline, so nothing can be overwritten.
  assign w_ce     = !out_valid || out_ready;
  assign in_ready = w_ce && !ap_rst;

  assign w_prod = din0 * din1;

  assign w_tail_vld   = r_vld[NUM_STAGE-1];
  assign w_tail_first = r_first[NUM_STAGE-1];
  assign w_tail_last  = r_last[NUM_STAGE-1];
  assign w_tail_prod  = r_prod[NUM_STAGE-1];

  assign w_acc_base = w_tail_first ? '0 : r_acc;
  assign w_acc_next = w_acc_base + ACC_WIDTH'(w_tail_prod);

  // One guard bit keeps the rounding add from wrapping.
  assign w_sum = (ACC_WIDTH + 1)'(w_acc_next) + ROUND_C;
  assign w_r   = w_sum >>> SHIFT;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_ovf  = 1'b0;
    w_dout = w_r[DOUT_WIDTH-1:0];
    if (w_r > MAX_C) begin
      w_ovf  = 1'b1;
      w_dout = MAX_C[DOUT_WIDTH-1:0];
    end else if (w_r < MIN_C) begin
      w_ovf  = 1'b1;
      w_dout = MIN_C[DOUT_WIDTH-1:0];
    end
  end

  // NOTE: payload registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge ap_clk) begin
    if (w_ce) begin
      r_prod[0]  <= w_prod;
      r_first[0] <= in_first;
      r_last[0]  <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_prod[i]  <= r_prod[i-1];
        r_first[i] <= r_first[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_vld     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (w_ce) begin
      r_vld[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      if (w_tail_vld) begin
        r_acc <= w_acc_next;
      end
      out_valid <= w_tail_vld && w_tail_last;
      if (w_tail_vld && w_tail_last) begin
        dout <= w_dout;
        ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fir_cascade_mac_pipe.sv
// Directed bench for fir_cascade_mac_pipe: default, 16-bit-output and SHIFT=4
// instances share one stimulus stream; each check targets the relevant copy.
module tb_fir_cascade_mac_pipe;

  logic ap_clk = 1'b0;
  logic ap_rst;
  logic in_valid, in_first, in_last, out_ready;
  logic signed [15:0] din0;
  logic signed [8:0]  din1;

  logic               a_in_ready, a_out_valid, a_ovf;
  logic signed [24:0] a_dout;
  logic               s_in_ready, s_out_valid, s_ovf;
  logic signed [15:0] s_dout;
  logic               r_in_ready, r_out_valid, r_ovf;
  logic signed [24:0] r_dout;

  int checks   = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  fir_cascade_mac_pipe u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(a_out_valid), .out_ready(out_ready), .dout(a_dout), .ovf(a_ovf)
  );

  fir_cascade_mac_pipe #(.DOUT_WIDTH(16)) u_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(s_out_valid), .out_ready(out_ready), .dout(s_dout), .ovf(s_ovf)
  );

  fir_cascade_mac_pipe #(.SHIFT(4)) u_rnd (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(r_out_valid), .out_ready(out_ready), .dout(r_dout), .ovf(r_ovf)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after an edge; outputs are read 1 ns after the next edge.
  task automatic drive(input logic v, input logic signed [15:0] a,
                       input logic signed [8:0] b, input logic f, input logic l);
    in_valid = v;
    din0     = a;
    din1     = b;
    in_first = f;
    in_last  = l;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'sd0, 9'sd0, 1'b0, 1'b0);
  endtask

  initial begin
    int sent;
    int got;
    int stall;
    bit seen;

    ap_rst    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    din0      = '0;
    din1      = '0;

    // Reset state
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_dout", a_dout, 0);
    check("rst_ovf", a_ovf, 0);
    ap_rst = 1'b0;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);

    // Single-beat frame: 100 * -3, visible exactly two edges after acceptance
    drive(1'b1, 16'sd100, -9'sd3, 1'b1, 1'b1);
    check("single_lat0", a_out_valid, 0);
    idle();
    check("single_lat1", a_out_valid, 0);
    idle();
    check("single_valid", a_out_valid, 1);
    check("single_dout", a_dout, -300);
    check("single_ovf", a_ovf, 0);
    idle();
    check("single_one_cycle", a_out_valid, 0);

    // Four-beat frame: 100000 - 100000 - 2100 + 25
    drive(1'b1, 16'sd1000, 9'sd100, 1'b1, 1'b0);
    check("frame_b0", a_out_valid, 0);
    drive(1'b1, -16'sd2000, 9'sd50, 1'b0, 1'b0);
    check("frame_b1", a_out_valid, 0);
    drive(1'b1, 16'sd300, -9'sd7, 1'b0, 1'b0);
    check("frame_b2", a_out_valid, 0);
    drive(1'b1, 16'sd5, 9'sd5, 1'b0, 1'b1);
    check("frame_b3", a_out_valid, 0);
    idle();
    check("frame_b4", a_out_valid, 0);
    idle();
    check("frame_valid", a_out_valid, 1);
    check("frame_dout", a_dout, -2075);
    idle();
    check("frame_done", a_out_valid, 0);

    // Rounding with SHIFT=4: products 24, -24, 8, -8, 7
    drive(1'b1, 16'sd24, 9'sd1, 1'b1, 1'b1);
    drive(1'b1, -16'sd24, 9'sd1, 1'b1, 1'b1);
    drive(1'b1, 16'sd8, 9'sd1, 1'b1, 1'b1);
    check("rnd_v0", r_out_valid, 1);
    check("rnd_p24", r_dout, 2);
    drive(1'b1, -16'sd8, 9'sd1, 1'b1, 1'b1);
    check("rnd_m24", r_dout, -1);
    drive(1'b1, 16'sd7, 9'sd1, 1'b1, 1'b1);
    check("rnd_p8", r_dout, 1);
    idle();
    check("rnd_m8", r_dout, 0);
    idle();
    check("rnd_p7", r_dout, 0);
    check("rnd_ovf", r_ovf, 0);
    idle();

    // Backpressure: 8 single-beat frames, 5-cycle stall after the first result
    sent  = 0;
    got   = 0;
    stall = 0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (a_out_valid) seen = 1'b1;
      out_ready = !(seen && stall < 5);
      if (!out_ready) stall++;
      in_valid  = (sent < 8);
      din0      = 16'(sent + 1);
      din1      = 9'sd10;
      in_first  = 1'b1;
      in_last   = 1'b1;
      #1;
      if (!out_ready) begin
        check("bp_in_ready", a_in_ready, 0);
        check("bp_valid_held", a_out_valid, 1);
        check("bp_dout_held", a_dout, 10 * (got + 1));
      end
      if (a_out_valid && out_ready) begin
        check("bp_data", a_dout, 10 * (got + 1));
        got++;
      end
      if (in_valid && a_in_ready) sent++;
      @(posedge ap_clk);
      #1;
    end
    out_ready = 1'b1;
    check("bp_stall_len", stall, 5);
    check("bp_sent", sent, 8);
    check("bp_received", got, 8);
    check("bp_drained", a_out_valid, 0);
    idle();

    // Saturation at 16-bit output; the default copy shows the unclamped product
    drive(1'b1, 16'sd100, 9'sd100, 1'b1, 1'b1);
    drive(1'b1, 16'sd32767, 9'sd255, 1'b1, 1'b1);
    drive(1'b1, -16'sd32768, 9'sd255, 1'b1, 1'b1);
    check("sat_small_dout", s_dout, 10000);
    check("sat_small_ovf", s_ovf, 0);
    // Reset abort: two beats of a four-beat frame enter the pipeline
    drive(1'b1, 16'sd1000, 9'sd100, 1'b1, 1'b0);
    check("sat_pos_dout", s_dout, 32767);
    check("sat_pos_ovf", s_ovf, 1);
    check("wide_pos_dout", a_dout, 8355585);
    check("wide_pos_ovf", a_ovf, 0);
    drive(1'b1, 16'sd300, -9'sd7, 1'b0, 1'b0);
    check("sat_neg_dout", s_dout, -32768);
    check("sat_neg_ovf", s_ovf, 1);

    ap_rst   = 1'b1;
    in_valid = 1'b0;
    #1;
    check("abort_in_ready", a_in_ready, 0);
    @(posedge ap_clk);
    #1;
    check("abort_out_valid", s_out_valid, 0);
    check("abort_dout", s_dout, 0);
    check("abort_ovf", s_ovf, 0);
    check("abort_dout_wide", a_dout, 0);
    ap_rst = 1'b0;
    #1;
    check("abort_in_ready_after", a_in_ready, 1);

    // Fresh traffic: a non-first beat onto the cleared accumulator, then -8 + 25
    drive(1'b1, 16'sd7, 9'sd3, 1'b0, 1'b1);
    check("fresh_lat0", a_out_valid, 0);
    drive(1'b1, -16'sd2, 9'sd4, 1'b1, 1'b0);
    check("fresh_lat1", a_out_valid, 0);
    drive(1'b1, 16'sd5, 9'sd5, 1'b0, 1'b1);
    check("fresh_nofirst_valid", a_out_valid, 1);
    check("fresh_nofirst_dout", a_dout, 21);
    idle();
    check("fresh_mid", a_out_valid, 0);
    idle();
    check("fresh_valid", a_out_valid, 1);
    check("fresh_dout", a_dout, 17);
    idle();
    check("fresh_done", a_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
